shifter_unit: RTL and testbench

- 32-bit registered barrel shifter for the integer execute stage of the RISC-V core.
- Implements the RV32I shift operations SLL, SRL and SRA (register and immediate forms) on operand a by shift amount b.
- Result is registered: one-cycle latency from input sample to output.

---
 rtl/shifter_unit.sv | 91 +++++++++
 tb/tb_shifter_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shifter_unit.sv
// shifter_unit: registered 32-bit barrel shifter for the integer execute stage.
// Implements SLL, SRL and SRA with one cycle of latency.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset, clears y and out_valid
//   in_valid  - a, b, mode and sel are valid this cycle
//   a         - operand to shift
//   b         - unsigned shift amount
//   mode      - right-shift type: 0 logical, 1 arithmetic
//   sel       - direction: 0 left, 1 right
//   y         - registered shift result
//   out_valid - y holds the result of the operation accepted last cycle
module shifter_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic               mode,
  input  logic               sel,
  output logic [WIDTH-1:0]   y,
  output logic               out_valid
);

  logic [WIDTH-1:0] a_rev;
  logic [WIDTH-1:0] core_in;
  logic [WIDTH-1:0] core_out;
  logic [WIDTH-1:0] core_out_rev;
  logic [WIDTH-1:0] result;
  logic             fill;

  logic [WIDTH-1:0] y_d, y_q;
  logic             out_valid_d, out_valid_q;

  // Left shifts reuse the right-shift core by reversing bit order on both sides.
  always_comb begin
    a_rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      a_rev[i] = a[WIDTH-1-i];
    end
  end

  assign core_in = sel ? a : a_rev;
  // Gating with sel keeps an undriven mode from leaking into left shifts.
  assign fill    = mode & sel & a[WIDTH-1];

  // Logarithmic right-shift core: stage s shifts by 2**s when b[s] is set.
  logic [WIDTH-1:0] stage [SHAMT_W+1];
  assign stage[0] = core_in;

  for (genvar s = 0; s < int'(SHAMT_W); s++) begin : g_stage
    localparam int unsigned Amt = 1 << s;
    assign stage[s+1] = b[s] ? {{Amt{fill}}, stage[s][WIDTH-1:Amt]} : stage[s];
  end

  assign core_out = stage[SHAMT_W];

  always_comb begin
    core_out_rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      core_out_rev[i] = core_out[WIDTH-1-i];
    end
  end

  assign result = sel ? core_out : core_out_rev;

  always_comb begin
    y_d         = y_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      y_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shifter_unit.sv
// tb_shifter_unit: self-checking bench for shifter_unit, directed and random shifts
// compared against a plain-arithmetic reference model.
module tb_shifter_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [4:0]  b;
  logic        mode;
  logic        sel;
  logic [31:0] y;
  logic        out_valid;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  shifter_unit #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .sel      (sel),
    .y        (y),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] amt,
                                            input logic m, input logic s);
    logic signed [31:0] sop;
    sop = op;
    if (!s)      return op << amt;
    else if (!m) return op >> amt;
    else         return sop >>> amt;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one valid op, then check its result one edge later.
  task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] amt,
                        input logic m, input logic s);
    @(negedge clk);
    in_valid = 1'b1;
    a        = op;
    b        = amt;
    mode     = m;
    sel      = s;
    @(posedge clk);
    #1;
    check_eq(tag, y, ref_shift(op, amt, m, s));
    check_eq({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_random(input string tag, input logic m, input logic s);
    for (int i = 0; i < 5; i++) begin
      run_op(tag, $urandom, 5'($urandom_range(0, 31)), m, s);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 32'hFFFF_FFFF;
    b        = 5'd3;
    mode     = 1'b0;
    sel      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_y", y, 32'h0);
    check_eq("rst_vld", {31'd0, out_valid}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    a     = 32'h0;
    b     = 5'd0;
    sel   = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_y", y, 32'h0);
    check_eq("post_rst_vld", {31'd0, out_valid}, 32'd1);

    // SLL
    run_op("sll_a", 32'h8000_0001, 5'd4, 1'b0, 1'b0);
    check_eq("sll_a_const", y, 32'h0000_0010);
    run_op("sll_b", 32'h1234_5678, 5'd31, 1'b0, 1'b0);
    check_eq("sll_b_const", y, 32'h0000_0000);
    run_random("sll_rnd", 1'b0, 1'b0);

    // SRL
    run_op("srl_a", 32'h8000_0000, 5'd31, 1'b0, 1'b1);
    check_eq("srl_a_const", y, 32'h0000_0001);
    run_op("srl_b", 32'hF000_000F, 5'd4, 1'b0, 1'b1);
    check_eq("srl_b_const", y, 32'h0F00_0000);
    run_random("srl_rnd", 1'b0, 1'b1);

    // SRA
    run_op("sra_a", 32'h8000_0000, 5'd31, 1'b1, 1'b1);
    check_eq("sra_a_const", y, 32'hFFFF_FFFF);
    run_op("sra_b", 32'h7000_0000, 5'd4, 1'b1, 1'b1);
    check_eq("sra_b_const", y, 32'h0700_0000);
    run_op("sra_c", 32'hF000_000F, 5'd4, 1'b1, 1'b1);
    check_eq("sra_c_const", y, 32'hFF00_0000);
    run_random("sra_rnd", 1'b1, 1'b1);

    // Zero shift and mode ignored on left shifts
    run_op("b0_sll", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
    check_eq("b0_sll_const", y, 32'hDEAD_BEEF);
    run_op("b0_srl", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1);
    check_eq("b0_srl_const", y, 32'hDEAD_BEEF);
    run_op("b0_sra", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1);
    check_eq("b0_sra_const", y, 32'hDEAD_BEEF);
    run_op("sll_mode1", 32'h0000_0001, 5'd3, 1'b1, 1'b0);
    check_eq("sll_mode1_const", y, 32'h0000_0008);
    run_op("sll_mode1_neg", 32'h8000_0010, 5'd2, 1'b1, 1'b0);
    check_eq("sll_mode1_neg_const", y, 32'h0000_0040);

    // Back-to-back ops, then a bubble that must hold y
    run_op("pipe_sll", 32'hC000_0003, 5'd1, 1'b0, 1'b0);
    run_op("pipe_srl", 32'hC000_0003, 5'd1, 1'b0, 1'b1);
    run_op("pipe_sra", 32'hC000_0003, 5'd1, 1'b1, 1'b1);
    check_eq("pipe_sra_const", y, 32'hE000_0001);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'h1111_1111;
    @(posedge clk);
    #1;
    check_eq("idle_vld", {31'd0, out_valid}, 32'd0);
    check_eq("idle_hold", y, 32'hE000_0001);
    @(posedge clk);
    #1;
    check_eq("idle_hold2", y, 32'hE000_0001);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_y", y, 32'h0);
    check_eq("async_rst_vld", {31'd0, out_valid}, 32'd0);

    // An op presented while in reset produces nothing
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hFFFF_FFFF;
    b        = 5'd1;
    sel      = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_discard_y", y, 32'h0);
    check_eq("rst_discard_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_release_vld", {31'd0, out_valid}, 32'd0);
    check_eq("rst_release_y", y, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
